// File: rtl/reg_scoreboard_if.sv
// ID-stage scoreboard bundle: decode-side request signals and hazard/shadow results.
// Optional perf counters appear only when SB_PERF_EN is defined.
interface reg_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  id_branch;
    logic                  id_jump;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_we;
    logic                  id_is_load;
    logic                  flush;
    logic                  freeze;
    logic                  stall;
    logic [NUM_REGS-1:0]   pending_mask;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [REG_ADDR_W-1:0] wb_rd;
`ifdef SB_PERF_EN
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      load_use_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_branch, id_jump, id_valid, id_rd,
        output id_reg_we, id_is_load, flush, freeze,
        input  stall, pending_mask, ex_rd, mem_rd, wb_rd
`ifdef SB_PERF_EN
        , input stall_cycles, load_use_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_branch, id_jump, id_valid, id_rd,
        input  id_reg_we, id_is_load, flush, freeze,
        output stall, pending_mask, ex_rd, mem_rd, wb_rd
`ifdef SB_PERF_EN
        , output stall_cycles, load_use_cnt
`endif
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Shadow EX/MEM/WB destination tracker driving the ID data-hazard interlock.
// Optional macro SB_PERF_EN adds saturating stall / load-use event counters.
module reg_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int CNT_W      = 32
) (
    input logic           clk,
    input logic           rst_n,
    reg_scoreboard_if.slave sb
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  ld;
    } slot_t;

    if (NUM_REGS != 2**REG_ADDR_W || CNT_W < 1) begin : g_bad_cfg
        $error("reg_scoreboard: bad parameters");
    end

    slot_t ex_q, mem_q, wb_q, ex_d;

    logic ex1, ex2, mem1, mem2;
    logic load_use, ctrl_ex, ctrl_mem, stall_w;
    logic [NUM_REGS-1:0] mask_w;

    function automatic logic hit(slot_t s, logic [REG_ADDR_W-1:0] rs);
        return (rs != '0) && s.valid && s.we && (s.rd == rs);
    endfunction

    always_comb begin
        ex1  = hit(ex_q, sb.id_rs1);
        ex2  = hit(ex_q, sb.id_rs2);
        mem1 = hit(mem_q, sb.id_rs1) && mem_q.ld;
        mem2 = hit(mem_q, sb.id_rs2) && mem_q.ld;
        load_use = ex_q.ld && ((sb.id_use_rs1 && ex1) ||
                               (sb.id_use_rs2 && ex2));
        ctrl_ex  = (sb.id_branch && (ex1 || ex2)) ||
                   (sb.id_jump && ex1);
        ctrl_mem = (sb.id_branch && (mem1 || mem2)) ||
                   (sb.id_jump && mem1);
        // flush kills the ID instruction, so it can never need a stall
        stall_w = sb.id_valid && !sb.flush &&
                  (load_use || ctrl_ex || ctrl_mem);
    end

    always_comb begin
        ex_d       = '0;
        ex_d.valid = sb.id_valid && !stall_w && !sb.flush;
        ex_d.rd    = sb.id_rd;
        ex_d.we    = sb.id_reg_we;
        ex_d.ld    = sb.id_is_load;
    end

    always_comb begin
        mask_w = '0;
        if (ex_q.valid && ex_q.we && ex_q.rd != '0)
            mask_w[ex_q.rd] = 1'b1;
        if (mem_q.valid && mem_q.we && mem_q.rd != '0)
            mask_w[mem_q.rd] = 1'b1;
        if (wb_q.valid && wb_q.we && wb_q.rd != '0)
            mask_w[wb_q.rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!sb.freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
        end
    end

    assign sb.stall        = stall_w;
    assign sb.pending_mask = mask_w;
    assign sb.ex_rd        = ex_q.valid  ? ex_q.rd  : '0;
    assign sb.mem_rd       = mem_q.valid ? mem_q.rd : '0;
    assign sb.wb_rd        = wb_q.valid  ? wb_q.rd  : '0;

`ifdef SB_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, lu_cnt_q;
    logic             lu_prev_q;
    logic             lu_stall;

    assign lu_stall = sb.id_valid && !sb.flush && load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
            lu_prev_q   <= 1'b0;
        end else begin
            lu_prev_q <= lu_stall;
            if (stall_w && !sb.freeze && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (lu_stall && !lu_prev_q && !(&lu_cnt_q))
                lu_cnt_q <= lu_cnt_q + 1'b1;
        end
    end

    assign sb.stall_cycles = stall_cnt_q;
    assign sb.load_use_cnt = lu_cnt_q;
`endif
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side companion to the ID-stage forwarding unit in the 5-stage pipelined core.
- Keeps a shadow pipeline of in-flight destination registers for the EX, MEM and WB slots, and marks which of them are loads.
- Raises the ID stall (data-hazard interlock) whenever forwarding cannot deliver an operand in time.
- Exports a pending-write mask so the debug logic and the forwarding unit see the same view of in-flight register writes.

Parameters:
REG_ADDR_W, 5, register index width
NUM_REGS, 32, number of architectural registers (2**REG_ADDR_W)
CNT_W, 32, perf counter width (used only with SB_PERF_EN)

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
id_rs1  input  REG_ADDR_W  source 1 of the instruction in ID
id_rs2  input  REG_ADDR_W  source 2 of the instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_branch  input  1  ID instruction is a conditional branch (compares in ID)
id_jump  input  1  ID instruction is jalr (rs1 read in ID)
id_valid  input  1  ID holds a real instruction
id_rd  input  REG_ADDR_W  destination of the ID instruction
id_reg_we  input  1  ID instruction writes rd
id_is_load  input  1  ID instruction is a load
flush  input  1  kill the instruction in ID (taken branch or jump)
freeze  input  1  global pipeline hold (memory wait); all state holds
stall  output  1  hold PC and IF/ID, insert bubble into EX
pending_mask  output  NUM_REGS  bit r set = register r has an in-flight write
ex_rd, mem_rd, wb_rd  output  REG_ADDR_W each  shadow rd per slot (0 when the slot is empty)

Behaviour:
- Slot state: ex, mem and wb slots, each holding {valid, rd, we, is_load}.
- Reset (async, rst_n=0): all slots invalid, rd=0. Outputs at reset: stall=0, pending_mask=0, ex_rd/mem_rd/wb_rd=0.
- Register x0 never matches, never stalls, and never sets pending_mask.
- Hazard terms (combinational from the current slots and the ID inputs):
  - match_ex(rs) = rs!=0 & ex.valid & ex.we & ex.rd==rs
  - load_use = (id_use_rs1 & match_ex(rs1) & ex.is_load) | (id_use_rs2 & match_ex(rs2) & ex.is_load)
  - ctrl_ex = (id_branch & (match_ex(rs1)|match_ex(rs2))) | (id_jump & match_ex(rs1))
  - ctrl_mem = the same as ctrl_ex, but using the mem slot and requiring mem.is_load
- stall = id_valid & ~flush & (load_use | ctrl_ex | ctrl_mem).
- Advance on each clk edge when freeze=0:
  - wb <= mem; mem <= ex.
  - ex <= {id_valid & ~stall & ~flush, id_rd, id_reg_we, id_is_load}.
  - While stalled, the bubble enters ex and ID holds its instruction.
- freeze=1: all slots hold. stall is still evaluated combinationally; the pipeline ignores it while frozen.
- flush and a stall condition in the same cycle: flush wins. stall=0 and a bubble enters ex.
- pending_mask = OR of one-hot(rd) over valid slots with we=1. A register written by two in-flight instructions shows one bit.
- Resulting stall counts:
  - ALU op -> dependent ALU op: 0 stalls.
  - Load -> dependent ALU op: 1 stall.
  - ALU op -> dependent branch: 1 stall.
  - Load -> dependent branch or jalr: 2 stalls.
- Reset asserted mid-stall: slots clear at once; stall drops in the same cycle.

Optional Feature:
SB_PERF_EN.
- Defined:
  - Adds output stall_cycles (CNT_W), counting cycles with stall=1 & freeze=0.
  - Adds output load_use_cnt (CNT_W), counting distinct load-use events: a rising edge of load_use-caused stall.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent, and the block is otherwise identical.

Test Plan:
- Stall-free ALU chain: issue add x5 then add x6,x5,x1 -> stall=0 throughout; pending_mask bit5 set for 3 cycles after issue.
- Load-use: issue lw x7 then add x8,x7,x2 -> stall=1 for exactly 1 cycle; ex slot shows rd=0 during the bubble; add enters ex the next cycle.
- Branch after load: lw x3, then beq x3,x0 -> stall=1 for 2 consecutive cycles, then 0.
- Branch after ALU: addi x4 then jalr x0,0(x4) -> 1 stall cycle. The same sequence with rd=x0 -> 0 stalls.
- Flush priority: load-use condition present with flush=1 -> stall=0, ex slot invalid next cycle. freeze=1 for 3 cycles mid-sequence -> ex_rd/mem_rd/wb_rd unchanged.
- Async reset with slots full and stall=1: drop rst_n between clock edges -> stall, pending_mask and all rd outputs 0 immediately. With SB_PERF_EN defined, the counters read 0 after reset and 1 after the next single load-use event.
